conv_feeder: RTL and testbench
==============================

# conv_feeder

Sequencer that drives the `convolution` multiply-accumulate unit, acting as the producer side of its `in1`/`in2`/`en`/`clear` stream protocol. It walks every valid (stride 1, no padding) output position of a feature map. For each position it streams the kernel-sized image window and the kernel weights out of two synchronous RAMs. It forces the accumulator's boundary sample after the last window and writes each saturated result, tagged with its output index, to a result memory. It sits between the image/kernel buffers and the result buffer in the pattern-detection datapath.

## Interface
- No parameters; all widths are fixed by the accumulator: 9-bit signed samples, 21-bit results.
- clk  in  1  system clock; single clock domain, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- img_w, img_h  in  9 each  image dimensions.
- k_w, k_h  in  9 each  kernel dimensions.
- img_addr  out  18  image RAM read address.
- img_data  in  9  signed; valid one cycle after `img_addr`.
- ker_addr  out  10  kernel RAM read address.
- ker_data  in  9  signed; valid one cycle after `ker_addr`.
- conv_in1, conv_in2  out  9 each  signed operands to the accumulator.
- conv_en  out  1  accumulator enable.
- conv_clear  out  1  accumulator clear.
- conv_height, conv_width  out  9 each  drive the accumulator's `height`/`width` ports.
- conv_out  in  21  accumulator result, two's complement.
- res_valid  out  1  one-cycle write strobe for the result memory.
- res_addr  out  18  output index n = oy*out_w + ox.
- res_data  out  21  result value.
- busy  out  1  high whenever the state is not IDLE.
- finished  out  1  one-cycle pulse marking frame completion.
- cfg_err  out  1  one-cycle pulse marking a rejected configuration.

## Operation
- Geometry: out_w = img_w - k_w + 1, out_h = img_h - k_h + 1, N = out_w*out_h, K = k_w*k_h.
- Address loop order: kx fastest, then ky, then ox, then oy.
  - img_addr = (oy+ky)*img_w + (ox+kx).
  - ker_addr = ky*k_w + kx.
- Configuration is latched on `start`. `conv_height`/`conv_width` hold the latched k_h/k_w for the whole frame.
- Configuration is rejected when any of the following holds: k_w = 0, k_h = 0, k_w > img_w, k_h > img_h, or K > 1023 (the accumulator counter is 10 bits).
  - On rejection: `cfg_err` pulses in the cycle after `start`, then the block returns to IDLE with no RAM or accumulator activity.
- States:
  - IDLE: on `start` with a valid configuration, go to CLEAR.
  - CLEAR: one cycle, `conv_clear`=1; then STREAM.
  - STREAM: one address pair issued per cycle, back-to-back across all windows, N*K cycles; then FLUSH.
  - FLUSH: one cycle; no address issued; a flush token enters the pipeline.
  - DRAIN: two cycles; then IDLE.
- Operand path:
  - `conv_en` is the address-issue strobe delayed by one cycle.
  - `conv_in1` = `img_data`, `conv_in2` = `ker_data`, except on the flush token, where both are forced to 0 with `conv_en`=1. The flush token supplies the boundary sample that emits window N-1.
- Result capture:
  - The accumulator emits window n-1 when sample 0 of window n (or the flush token) is enabled.
  - A pipelined boundary flag asserts `res_valid` two cycles after the corresponding address issue, with `res_data` = `conv_out`.
  - `res_addr` increments from 0 to N-1.
  - The `done` output of the accumulator is not used.
- `start` while busy is ignored.
- `rst` mid-frame returns the block to IDLE within one cycle. Results already written stay written; the frame is not resumed.
- Reset values: all outputs 0.

## Timing
- `start` high in cycle 0.
- Cycle 1: CLEAR.
- Cycles 2 .. N*K+1: addresses issued.
- `res_valid` for window n falls in cycle K*(n+1)+4.
- The last result appears in cycle N*K+4. `finished`=1 in that same cycle, and `busy` drops the next cycle.
- A new `start` is accepted in cycle N*K+5.
- With K=1, `res_valid` is high every cycle from cycle 5 onward.

## Configuration
- `CONV_FEEDER_RELU_EN`
  - Defined: `res_data` = 0 whenever `conv_out` is negative (bit 20 set); otherwise `conv_out`. This adds no latency.
  - Undefined: `res_data` = `conv_out` unmodified.

## Test plan
- 4x4 image with p(r,c) = 4r+c, 2x2 kernel [1,0;0,1] -> 9 results at cycles 8, 12, …, 40. Values are 2(4oy+ox)+5, e.g. n=0 gives 5 and n=8 gives 25. `finished` pulses in cycle 40.
- Same image with kernel [1,0;0,-1] -> every result is -5 (0x1FFFFB) without the macro and 0 with `CONV_FEEDER_RELU_EN`.
- 31x31 image of all -256 with a 31x31 kernel of all -256 -> a single result 0x0FFFFF (saturated), N*K = 961.
- k_w = 5 with img_w = 4 -> `cfg_err` pulses in cycle 1; `conv_en`, `res_valid` and `busy` stay 0.
- `rst` asserted in cycle 10 of the first scenario -> all outputs are 0 from cycle 11. A following `start` reruns the frame and produces all 9 results correctly.
- 3x3 image with a 1x1 kernel of value 2 -> 9 consecutive `res_valid` cycles, 5 through 13, each result equal to 2*pixel.

Source files
------------

// File: rtl/conv_feeder_if.sv
// conv_feeder_if: groups the frame-control, RAM, accumulator and result-memory
// signals of conv_feeder. The master modport is the feeder side; slave is the
// surrounding datapath (RAMs, accumulator, result buffer).
interface conv_feeder_if;
    logic              start;
    logic [8:0]        img_w;
    logic [8:0]        img_h;
    logic [8:0]        k_w;
    logic [8:0]        k_h;
    logic [17:0]       img_addr;
    logic signed [8:0] img_data;
    logic [9:0]        ker_addr;
    logic signed [8:0] ker_data;
    logic signed [8:0] conv_in1;
    logic signed [8:0] conv_in2;
    logic              conv_en;
    logic              conv_clear;
    logic [8:0]        conv_height;
    logic [8:0]        conv_width;
    logic [20:0]       conv_out;
    logic              res_valid;
    logic [17:0]       res_addr;
    logic [20:0]       res_data;
    logic              busy;
    logic              finished;
    logic              cfg_err;

    modport master (
        input  start, img_w, img_h, k_w, k_h, img_data, ker_data, conv_out,
        output img_addr, ker_addr, conv_in1, conv_in2, conv_en, conv_clear,
               conv_height, conv_width, res_valid, res_addr, res_data,
               busy, finished, cfg_err
    );

    modport slave (
        output start, img_w, img_h, k_w, k_h, img_data, ker_data, conv_out,
        input  img_addr, ker_addr, conv_in1, conv_in2, conv_en, conv_clear,
               conv_height, conv_width, res_valid, res_addr, res_data,
               busy, finished, cfg_err
    );
endinterface

// File: rtl/conv_feeder.sv
// conv_feeder: walks every stride-1 output position of a feature map, streams
// image window + kernel weights to the MAC accumulator, appends a flush token
// after the last window and writes each accumulator result to result memory.
// Optional feature macro: CONV_FEEDER_RELU_EN (clamp negative results to 0).
module conv_feeder (
    input  logic          clk,
    input  logic          rst,
    conv_feeder_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DRAIN} state_t;
    state_t state, state_nx;

    logic [8:0]  img_w_q, k_w_q, k_h_q, out_w, out_h;
    logic [8:0]  kx, ky, ox, oy;
    logic [17:0] row_base, oy_base;  // (oy+ky)*img_w and oy*img_w
    logic [9:0]  kidx;
    logic [17:0] res_cnt;
    logic        drain_cnt;
    logic        en_d1, flush_d1;
    logic [1:0]  bnd_pipe;           // window-boundary flag, issue -> result
    logic        cfg_err_q;

    logic [17:0] k_area;
    logic        cfg_ok, accept, issue, flush;
    logic        kx_last, ky_last, ox_last, oy_last;
    logic        win_first, frame_first;
    logic [20:0] res_val;

    assign k_area  = {9'd0, bus.k_w} * {9'd0, bus.k_h};
    assign cfg_ok  = (bus.k_w != 9'd0) && (bus.k_h != 9'd0) &&
                     (bus.k_w <= bus.img_w) && (bus.k_h <= bus.img_h) &&
                     (k_area <= 18'd1023);
    assign accept  = (state == IDLE) && bus.start && cfg_ok;
    assign issue   = (state == STREAM);
    assign flush   = (state == FLUSH);

    assign kx_last     = (kx == k_w_q - 9'd1);
    assign ky_last     = (ky == k_h_q - 9'd1);
    assign ox_last     = (ox == out_w - 9'd1);
    assign oy_last     = (oy == out_h - 9'd1);
    assign win_first   = (kx == 9'd0) && (ky == 9'd0);
    assign frame_first = (ox == 9'd0) && (oy == 9'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CLEAR;
            CLEAR:   state_nx = STREAM;
            STREAM:  if (kx_last && ky_last && ox_last && oy_last) state_nx = FLUSH;
            FLUSH:   state_nx = DRAIN;
            DRAIN:   if (drain_cnt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Config latch, window/position counters and incremental address bases
    always_ff @(posedge clk) begin
        if (rst) begin
            img_w_q <= '0; k_w_q <= '0; k_h_q <= '0; out_w <= '0; out_h <= '0;
            kx <= '0; ky <= '0; ox <= '0; oy <= '0;
            row_base <= '0; oy_base <= '0; kidx <= '0; drain_cnt <= 1'b0;
        end else if (accept) begin
            img_w_q <= bus.img_w;
            k_w_q   <= bus.k_w;
            k_h_q   <= bus.k_h;
            out_w   <= bus.img_w - bus.k_w + 9'd1;
            out_h   <= bus.img_h - bus.k_h + 9'd1;
            kx <= '0; ky <= '0; ox <= '0; oy <= '0;
            row_base <= '0; oy_base <= '0; kidx <= '0;
        end else if (issue) begin
            if (!kx_last) begin
                kx   <= kx + 9'd1;
                kidx <= kidx + 10'd1;
            end else begin
                kx <= '0;
                if (!ky_last) begin
                    ky       <= ky + 9'd1;
                    kidx     <= kidx + 10'd1;
                    row_base <= row_base + {9'd0, img_w_q};
                end else begin
                    ky   <= '0;
                    kidx <= '0;
                    if (!ox_last) begin
                        ox       <= ox + 9'd1;
                        row_base <= oy_base;
                    end else begin
                        ox       <= '0;
                        oy       <= oy + 9'd1;
                        oy_base  <= oy_base + {9'd0, img_w_q};
                        row_base <= oy_base + {9'd0, img_w_q};
                    end
                end
            end
        end else if (flush) begin
            drain_cnt <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= 1'b1;
        end
    end

    // Operand/boundary pipeline and result counter
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d1 <= 1'b0; flush_d1 <= 1'b0; bnd_pipe <= '0;
            res_cnt <= '0; cfg_err_q <= 1'b0;
        end else begin
            en_d1     <= issue || flush;
            flush_d1  <= flush;
            // Sample 0 of window 0 emits nothing useful; every later window
            // start and the flush token release the previous window.
            bnd_pipe  <= {bnd_pipe[0], (issue && win_first && !frame_first) || flush};
            cfg_err_q <= (state == IDLE) && bus.start && !cfg_ok;
            if (accept)           res_cnt <= '0;
            else if (bnd_pipe[1]) res_cnt <= res_cnt + 18'd1;
        end
    end

`ifdef CONV_FEEDER_RELU_EN
    assign res_val = bus.conv_out[20] ? 21'd0 : bus.conv_out;
`else
    assign res_val = bus.conv_out;
`endif

    assign bus.img_addr    = issue ? row_base + {9'd0, ox} + {9'd0, kx} : 18'd0;
    assign bus.ker_addr    = issue ? kidx : 10'd0;
    assign bus.conv_en     = en_d1;
    assign bus.conv_in1    = (en_d1 && !flush_d1) ? bus.img_data : 9'sd0;
    assign bus.conv_in2    = (en_d1 && !flush_d1) ? bus.ker_data : 9'sd0;
    assign bus.conv_clear  = (state == CLEAR);
    assign bus.conv_height = k_h_q;
    assign bus.conv_width  = k_w_q;
    assign bus.res_valid   = bnd_pipe[1];
    assign bus.res_addr    = bnd_pipe[1] ? res_cnt : 18'd0;
    assign bus.res_data    = bnd_pipe[1] ? res_val : 21'd0;
    assign bus.busy        = (state != IDLE);
    assign bus.finished    = (state == DRAIN) && drain_cnt;
    assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: image/kernel RAM models, a behavioural MAC accumulator and a
// scoreboard of directly computed convolution results with their due cycles.
module tb_conv_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   c0 = 0;
    int   exp_fin = -1;

    conv_feeder_if bus ();

    conv_feeder dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Cycle counter: cycle c is the interval following the c-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [8:0] img_mem [0:262143];
    logic signed [8:0] ker_mem [0:1023];

    // Synchronous-read RAMs
    always @(posedge clk) begin
        bus.img_data <= img_mem[bus.img_addr];
        bus.ker_data <= ker_mem[bus.ker_addr];
    end

    function automatic logic [20:0] sat21(input int v);
        logic [31:0] t;
        if (v > 1048575)  return 21'h0FFFFF;
        if (v < -1048576) return 21'h100000;
        t = v;
        return t[20:0];
    endfunction

    // Behavioural accumulator: emits the previous window on each sample 0
    int acc = 0;
    int cnt = 0;
    logic [20:0] conv_out_r = '0;
    assign bus.conv_out = conv_out_r;
    always @(posedge clk) begin
        if (rst || bus.conv_clear) begin
            acc <= 0;
            cnt <= 0;
        end else if (bus.conv_en) begin
            if (cnt == 0) begin
                conv_out_r <= sat21(acc);
                acc <= int'(bus.conv_in1) * int'(bus.conv_in2);
            end else begin
                acc <= acc + int'(bus.conv_in1) * int'(bus.conv_in2);
            end
            cnt <= (cnt + 1 == int'(bus.conv_height) * int'(bus.conv_width)) ? 0 : cnt + 1;
        end
    end

    typedef struct { int addr; logic [20:0] data; int due; } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    // Result monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_res", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", int'(bus.res_data), int'(e.data));
                chk("res_addr", int'(bus.res_addr), e.addr);
                chk("res_cycle", cyc, e.due);
            end
        end
        if (bus.finished) chk("fin_cycle", cyc, exp_fin);
    end

    // Push expected results, then pulse start; returns in the CLEAR cycle
    task automatic launch(input int iw, input int ih, input int kw, input int kh);
        int ow, oh, k, n, s;
        logic [20:0] d;
        ow = iw - kw + 1; oh = ih - kh + 1; k = kw * kh;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++) begin
                s = 0;
                for (int ky = 0; ky < kh; ky++)
                    for (int kx = 0; kx < kw; kx++)
                        s += int'(img_mem[(oy+ky)*iw + ox + kx]) * int'(ker_mem[ky*kw + kx]);
                d = sat21(s);
`ifdef CONV_FEEDER_RELU_EN
                if (d[20]) d = '0;
`endif
                n = oy * ow + ox;
                exp_q.push_back('{addr: n, data: d, due: cyc + k*(n+1) + 4});
            end
        bus.img_w = iw[8:0]; bus.img_h = ih[8:0]; bus.k_w = kw[8:0]; bus.k_h = kh[8:0];
        bus.start = 1'b1;
        c0 = cyc;
        exp_fin = c0 + ow*oh*k + 4;
        @(negedge clk);
        bus.start = 1'b0;
        chk("clear_pulse", int'(bus.conv_clear), 1);
        chk("busy_run", int'(bus.busy), 1);
        chk("conv_width", int'(bus.conv_width), kw);
        chk("conv_height", int'(bus.conv_height), kh);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", int'(bus.busy), 0);
        chk("idle_cycle", cyc, exp_fin + 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic fill_ramp4();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img_mem[r*4 + c] = 9'(4*r + c);
    endtask

    int bad_cfg [3][4] = '{'{4, 4, 5, 2}, '{4, 4, 0, 2}, '{40, 40, 32, 32}};

    initial begin
        bus.start = 0; bus.img_w = 0; bus.img_h = 0; bus.k_w = 0; bus.k_h = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_conv_en", int'(bus.conv_en), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
        chk("rst_img_addr", int'(bus.img_addr), 0);
        chk("rst_conv_w", int'(bus.conv_width), 0);
        rst = 1'b0;
        @(negedge clk);

        // 4x4 ramp, diagonal identity kernel
        fill_ramp4();
        ker_mem[0] = 1; ker_mem[1] = 0; ker_mem[2] = 0; ker_mem[3] = 1;
        launch(4, 4, 2, 2);
        wait_idle();

        // Same image, kernel [1,0;0,-1]: all results negative
        @(negedge clk);
        ker_mem[3] = -1;
        launch(4, 4, 2, 2);
        wait_idle();

        // 31x31 of -256 with 31x31 kernel of -256: saturates positive
        @(negedge clk);
        for (int i = 0; i < 961; i++) begin img_mem[i] = -256; ker_mem[i] = -256; end
        launch(31, 31, 31, 31);
        wait_idle();

        // Rejected configurations: no activity, cfg_err one cycle after start
        foreach (bad_cfg[j]) begin
            @(negedge clk);
            bus.img_w = 9'(bad_cfg[j][0]); bus.img_h = 9'(bad_cfg[j][1]);
            bus.k_w = 9'(bad_cfg[j][2]);   bus.k_h = 9'(bad_cfg[j][3]);
            bus.start = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                bus.start = 1'b0;
                chk("cfg_err", int'(bus.cfg_err), (i == 1) ? 1 : 0);
                chk("cfg_no_en", int'(bus.conv_en), 0);
                chk("cfg_no_res", int'(bus.res_valid), 0);
                chk("cfg_no_busy", int'(bus.busy), 0);
            end
        end

        // Mid-frame reset in cycle 10, then a full rerun with an ignored start
        @(negedge clk);
        fill_ramp4();
        ker_mem[0] = 1; ker_mem[1] = 0; ker_mem[2] = 0; ker_mem[3] = 1;
        launch(4, 4, 2, 2);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_fin = -1;
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_conv_en", int'(bus.conv_en), 0);
        chk("mrst_img_addr", int'(bus.img_addr), 0);
        chk("mrst_ker_addr", int'(bus.ker_addr), 0);
        chk("mrst_in1", int'(bus.conv_in1), 0);
        chk("mrst_res_valid", int'(bus.res_valid), 0);
        chk("mrst_conv_h", int'(bus.conv_height), 0);
        @(negedge clk);
        launch(4, 4, 2, 2);
        repeat (18) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // 3x3 image, 1x1 kernel of 2: results every cycle 5..13
        @(negedge clk);
        for (int i = 0; i < 9; i++) img_mem[i] = 9'(i*13 - 50);
        ker_mem[0] = 2;
        launch(3, 3, 1, 1);
        wait_idle();

        // Random 6x5 image, 3x2 kernel
        @(negedge clk);
        for (int i = 0; i < 30; i++) img_mem[i] = 9'($urandom_range(511));
        for (int i = 0; i < 6; i++)  ker_mem[i] = 9'($urandom_range(511));
        launch(6, 5, 3, 2);
        wait_idle();

        // Largest accepted kernel: K = 33*31 = 1023, single output
        @(negedge clk);
        for (int i = 0; i < 1023; i++) begin
            img_mem[i] = 9'($urandom_range(511));
            ker_mem[i] = 9'($urandom_range(511));
        end
        launch(33, 31, 33, 31);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
